// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             last_bit;
    logic             load;
    logic             shift;
    logic             finish;
    logic             retire;

    logic             d1;
    logic             b1;
    logic             cell_d;
    logic             cell_b;

    // Full-subtractor cell as two cascaded half-subtractors; with br=0 it is the plain half cell.
    always_comb begin
        d1     = a_sr[0] ^ b_sr[0];
        b1     = ~a_sr[0] & b_sr[0];
        cell_d = d1 ^ br;
        cell_b = b1 | (~d1 & br);
    end

    assign res_nxt  = {cell_d, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        shift  = 1'b0;
        finish = 1'b0;
        retire = 1'b0;
        case (state)
            IDLE:    load = start;
            RUN: begin
                shift  = 1'b1;
                finish = last_bit;
            end
            DONE:    retire = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
            cnt    <= '0;
        end else if (shift) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            br     <= cell_b;
            cnt    <= cnt + CW'(1);
        end
    end

    // diff/bout are only touched on the final bit so partial results never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                busy <= 1'b1;
            end else if (retire) begin
                busy <= 1'b0;
            end
            if (finish) begin
                diff <= res_nxt;
                bout <= cell_b;
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit unsigned subtractor built around a half/full-subtractor cell and a borrow flip-flop. It processes one bit per clock, LSB first.
- Operands are loaded on a start strobe.
- The result difference and final borrow are presented with a one-cycle done pulse.
- It is the sequential stage downstream of the combinational half-subtractor cell: it consumes the cell's difference/borrow outputs each cycle and extends the cell to multi-bit operands.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend, captured when start is accepted
b  input  WIDTH  subtrahend, captured when start is accepted
bin  input  1  borrow-in, captured when start is accepted (chaining)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; diff/bout valid
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values (rst=1, immediate, no clock needed):
  - state=IDLE
  - busy=0, done=0, diff=0, bout=0
  - internal shift registers, borrow flip-flop and bit counter = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge (E0): capture a, b and bin (bin goes into the borrow flip-flop), clear the counter and the result shift register, set busy=1, go to RUN.
  - If start=0: stay in IDLE; outputs hold.
- RUN: each edge processes the current LSBs a0, b0 and borrow br.
  - d = a0 ^ b0 ^ br
  - bn = (~a0 & b0) | (~(a0 ^ b0) & br)
  - With br=0 the cell reduces exactly to the half-subtractor: d = a0 ^ b0, bn = ~a0 & b0.
  - d shifts into the result MSB (the result register shifts right); a and b shift right; br <= bn; counter increments.
- RUN exit: after exactly WIDTH RUN edges (E1..EWIDTH), the edge EWIDTH:
  - loads diff with the completed result and bout with the final bn;
  - sets done=1;
  - moves the state to DONE.
- DONE: the next edge (E(WIDTH+1)) sets done=0 and busy=0 and moves the state to IDLE.
- Timing summary:
  - busy is high from E0 through E(WIDTH+1), i.e. WIDTH+1 cycles.
  - done is high for exactly one cycle.
  - Latency from the start-accept edge to the done-rising edge is WIDTH cycles.
- diff and bout change only at the RUN-exit edge or on reset. They hold their last values through IDLE and the next operation until that operation completes. No partial results are visible on diff.
- start is ignored in RUN and DONE, with no queuing; a and b may change freely while busy.
- Earliest next accept is the first edge in IDLE, after E(WIDTH+1). A start held high continuously therefore yields back-to-back operations with one IDLE cycle between them.
- Reset mid-operation: the operation is aborted, all outputs clear immediately, no done is issued. After rst is released, the block stays in IDLE until a fresh start.
- Arithmetic:
  - All unsigned.
  - diff wraps mod 2^WIDTH.
  - The counter is sized ceil(log2(WIDTH+1)) bits and must not wrap during RUN.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start for 1 cycle -> done pulse 8 cycles after the accept edge; diff=0x1E, bout=0; busy high 9 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 (wrap-around/underflow).
- a=0x80, b=0x80, bin=0 -> diff=0x00, bout=0; then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- start=1 held with a=0x05, b=0x03, and operands changed to a=0x01, b=0x02 mid-run -> first result diff=0x02, bout=0 (capture-at-accept). The second op is accepted only after one IDLE cycle and gives diff=0xFF, bout=1. No start is accepted during RUN/DONE.
- Assert rst at RUN bit 4 of a=0xAA, b=0x55 -> busy, done, diff and bout go to 0 immediately (asynchronously), no done pulse. A subsequent start with a=0xAA, b=0x55 -> diff=0x55, bout=0.
- Exhaustive sweep at WIDTH=4 over all a, b, bin -> diff == (a-b-bin) mod 16 and bout == (a < b+bin) for every case.
